// File: rtl/sync_pkg.sv
// Shared types and default sizing for the multi-group barrier collector.
package sync_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HIT  = 2'd2
    } sync_state_e;

    localparam int NODE_NUM_DEF = 12;
    localparam int GRP_NUM_DEF  = 4;
    localparam int TO_W_DEF     = 16;

endpackage

// File: rtl/sync_group_fsm.sv
// One barrier group: target mask, arrival buffer, WAIT-cycle timeout counter and
// the IDLE/WAIT/HIT state machine.
module sync_group_fsm
    import sync_pkg::*;
#(
    parameter int NODE_NUM = NODE_NUM_DEF,
    parameter int TO_W     = TO_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_fire,
    input  logic [NODE_NUM-1:0] init_target,
    input  logic                arr_vld,
    input  logic [NODE_NUM-1:0] arr_mask,
    input  logic                abort,
    input  logic [TO_W-1:0]     timeout_cfg,
    output logic [1:0]          state,
    output logic [NODE_NUM-1:0] target,
    output logic                hit,
    output logic                err_timeout
);

    sync_state_e         state_q, state_d;
    logic [NODE_NUM-1:0] target_q, target_d;
    logic [NODE_NUM-1:0] buf_q, buf_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic                err_to_q, err_to_d;
    logic [NODE_NUM-1:0] arr;
    logic [NODE_NUM-1:0] merged;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        err_to_d = 1'b0;
        arr      = arr_vld ? (arr_mask & target_q) : '0;
        // This cycle's arrival is folded in so completion costs no extra cycle.
        merged   = buf_q | arr;
        case (state_q)
            IDLE: begin
                if (init_fire) begin
                    state_d  = WAIT;
                    target_d = init_target;
                    buf_d    = '0;
                    cnt_d    = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + TO_W'(1);
                buf_d = merged;
                if (abort) begin
                    state_d = IDLE;
                    buf_d   = '0;
                end else if (merged == target_q) begin
                    state_d = HIT;
                end else if ((timeout_cfg != '0) && (cnt_q == timeout_cfg - TO_W'(1))) begin
                    state_d  = IDLE;
                    buf_d    = '0;
                    err_to_d = 1'b1;
                end
            end
            HIT: begin
                state_d = IDLE;
                buf_d   = '0;
            end
            default: begin
                state_d = IDLE;
                buf_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            buf_q    <= '0;
            cnt_q    <= '0;
            err_to_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            err_to_q <= err_to_d;
        end
    end

    assign state       = state_q;
    assign target      = target_q;
    assign hit         = (state_q == HIT);
    assign err_timeout = err_to_q;

endmodule

// File: rtl/sync_barrier_multi.sv
// Multi-group barrier collector: decodes init/request handshakes onto GRP_NUM
// independent group FSMs and reports stray requests and zero-target inits.
module sync_barrier_multi
    import sync_pkg::*;
#(
    parameter int NODE_NUM = NODE_NUM_DEF,
    parameter int GRP_NUM  = GRP_NUM_DEF,
    parameter int TO_W     = TO_W_DEF,
    localparam int NID_W   = (NODE_NUM > 1) ? $clog2(NODE_NUM) : 1,
    localparam int GID_W   = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_vld,
    input  logic [GID_W-1:0]    init_grp_id,
    input  logic [NODE_NUM-1:0] init_target,
    output logic                init_rdy,
    input  logic                req_vld,
    input  logic [GID_W-1:0]    req_grp_id,
    input  logic [NID_W-1:0]    req_node_id,
    output logic                req_rdy,
    input  logic [GRP_NUM-1:0]  grp_abort,
    input  logic [TO_W-1:0]     timeout_cfg,
    output logic [GRP_NUM-1:0]  hit,
    output logic [GRP_NUM-1:0]  err_timeout,
    output logic                err_stray,
    output logic                err_cfg,
    output logic [GRP_NUM-1:0]  grp_busy
);

    logic [1:0]          grp_state  [GRP_NUM];
    logic [NODE_NUM-1:0] grp_target [GRP_NUM];
    logic [GRP_NUM-1:0]  init_fire;
    logic [GRP_NUM-1:0]  arr_vld;
    logic [NODE_NUM-1:0] node_oh;
    logic [NODE_NUM-1:0] req_tgt;
    logic                init_acc, req_acc;
    logic                err_stray_q, err_stray_d;
    logic                err_cfg_q, err_cfg_d;

    // Out-of-range group/node ids match no decode entry, so they read as not-ready / stray.
    always_comb begin
        init_rdy  = 1'b0;
        req_rdy   = 1'b0;
        req_tgt   = '0;
        node_oh   = '0;
        init_fire = '0;
        arr_vld   = '0;
        for (int n = 0; n < NODE_NUM; n++) begin
            if (req_node_id == NID_W'(n)) node_oh[n] = 1'b1;
        end
        for (int g = 0; g < GRP_NUM; g++) begin
            if (init_grp_id == GID_W'(g)) init_rdy = (grp_state[g] == IDLE);
            if (req_grp_id == GID_W'(g)) begin
                req_rdy = (grp_state[g] == WAIT);
                req_tgt = grp_target[g];
            end
        end
        init_acc = init_vld & init_rdy;
        req_acc  = req_vld & req_rdy;
        for (int g = 0; g < GRP_NUM; g++) begin
            init_fire[g] = init_acc && (init_target != '0) && (init_grp_id == GID_W'(g));
            arr_vld[g]   = req_acc && (req_grp_id == GID_W'(g));
        end
        err_stray_d = req_acc && ((node_oh & req_tgt) == '0);
        err_cfg_d   = init_acc && (init_target == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_stray_q <= 1'b0;
            err_cfg_q   <= 1'b0;
        end else begin
            err_stray_q <= err_stray_d;
            err_cfg_q   <= err_cfg_d;
        end
    end

    for (genvar g = 0; g < GRP_NUM; g++) begin : g_grp
        sync_group_fsm #(
            .NODE_NUM (NODE_NUM),
            .TO_W     (TO_W)
        ) u_grp (
            .clk         (clk),
            .rst_n       (rst_n),
            .init_fire   (init_fire[g]),
            .init_target (init_target),
            .arr_vld     (arr_vld[g]),
            .arr_mask    (node_oh),
            .abort       (grp_abort[g]),
            .timeout_cfg (timeout_cfg),
            .state       (grp_state[g]),
            .target      (grp_target[g]),
            .hit         (hit[g]),
            .err_timeout (err_timeout[g])
        );
        assign grp_busy[g] = (grp_state[g] != IDLE);
    end

    assign err_stray = err_stray_q;
    assign err_cfg   = err_cfg_q;

endmodule
